det3_seq: RTL and testbench
===========================

DET3_SEQ -- requirements
Module: det3_seq

Interface
REQ-001 Parameter: WIDTH, 16, element/result width in bits.
REQ-002 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: clear  input  1  synchronous abort; discards partial matrix or result.
REQ-005 Port: in_valid  input  1  in_data holds a valid matrix element.
REQ-006 Port: in_ready  output  1  block accepts an element this cycle.
REQ-007 Port: in_data  input  WIDTH  matrix element, row-major order a1..a9.
REQ-008 Port: out_valid  output  1  result holds a completed determinant.
REQ-009 Port: out_ready  input  1  consumer accepts result.
REQ-010 Port: result  output  WIDTH  determinant, modulo 2^WIDTH, two's complement.
REQ-011 Port: busy  output  1  high in CALC and DONE.

Function
REQ-012 States SHALL be LOAD, CALC, DONE; reset state LOAD.
REQ-013 LOAD: in_ready=1; element captured on in_valid&&in_ready into arr[idx]; idx increments 0..8.
REQ-014 Acceptance of element idx=8 SHALL transition to CALC and reset the term counter to 0.
REQ-015 CALC SHALL use exactly one shared W-bit three-operand multiplier, one term per cycle, six cycles.
REQ-016 Term order: +a1a5a9, +a2a6a7, +a4a8a3, -a3a5a7, -a2a4a9, -a6a8a1.
REQ-017 Each product truncated to WIDTH bits; accumulator adds or subtracts it, wrapping modulo 2^WIDTH.
REQ-018 After the sixth term the state SHALL be DONE; out_valid rises 6 clock edges after the edge accepting a9.
REQ-019 DONE: out_valid=1, result=accumulator, both stable until out_valid&&out_ready.
REQ-020 Handshake in DONE SHALL return to LOAD with idx=0 and accumulator=0; in_ready rises the following cycle.
REQ-021 in_ready SHALL be 0 in CALC and DONE; in_valid there is ignored.
REQ-022 clear=1 in any state SHALL return to LOAD, zero idx, term counter and accumulator; clear beats a simultaneous in_valid or out_ready.
REQ-023 out_valid SHALL never assert in LOAD or CALC; result SHALL read 0 outside DONE.

Reset
REQ-024 reset SHALL immediately force LOAD, idx=0, term=0, accumulator=0, arr[1..9]=0.
REQ-025 Reset values: in_ready=1, out_valid=0, busy=0, result=0 (plus term outputs 0 when compiled in).
REQ-026 reset asserted mid-LOAD or mid-CALC SHALL discard all partial state; no result emitted.

Configuration
REQ-027 Macro DET3_SEQ_TERM_OUT_EN, when defined, SHALL add outputs term_valid(1), term_idx(3), term_data(WIDTH).
REQ-028 With the macro: in each CALC cycle term_valid=1, term_idx=0..5, term_data=unsigned truncated product before sign; else all 0.
REQ-029 Without the macro: those ports SHALL not exist; all other behaviour identical.

Verification
REQ-030 Load [1,0,0;0,1,0;0,0,1] -> out_valid 6 edges after a9, result=0x0001.
REQ-031 Load [1,2,3;0,1,4;5,6,0] -> result=0x0001; [1,2,3;4,5,6;7,8,9] -> result=0x0000; [0,1,0;1,0,0;0,0,1] -> 0xFFFF.
REQ-032 Load diag(2,3,4), hold out_ready=0 for 5 cycles -> result=0x0018 stable, in_ready=0 throughout; in_valid pulses ignored.
REQ-033 Pulse clear after 4 elements, then load identity -> result=0x0001 (partial data discarded).
REQ-034 Assert reset in third CALC cycle -> out_valid stays 0, in_ready=1 next cycle; following identity load gives 0x0001.
REQ-035 With DET3_SEQ_TERM_OUT_EN, load diag(2,3,4) -> term_data sequence 24,0,0,0,0,0 with term_idx 0..5.

Source files
------------

// File: rtl/det3_seq.sv
// Sequential 3x3 determinant: loads nine row-major elements, then folds six
// signed triple products through one shared multiplier. Optional per-term
// trace outputs under `DET3_SEQ_TERM_OUT_EN`.
module det3_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [1:0]       state_dbg
`ifdef DET3_SEQ_TERM_OUT_EN
  ,
  output logic             term_valid,
  output logic [2:0]       term_idx,
  output logic [WIDTH-1:0] term_data
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and held data is stable until taken.
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] arr [9];
  logic [3:0]       idx;
  logic [2:0]       term;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op_a, op_b, op_c;
  logic [WIDTH-1:0] prod;
  logic             neg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD:    if (in_valid && idx == 4'd8) state_nxt = CALC;
        CALC:    if (term == 3'd5) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = LOAD;
        default: state_nxt = LOAD;
      endcase
    end
  end

  // Term order: three positive diagonals, then three negative anti-diagonals.
  always_comb begin
    op_a = '0;
    op_b = '0;
    op_c = '0;
    neg  = 1'b0;
    case (term)
      3'd0: begin op_a = arr[0]; op_b = arr[4]; op_c = arr[8]; end
      3'd1: begin op_a = arr[1]; op_b = arr[5]; op_c = arr[6]; end
      3'd2: begin op_a = arr[3]; op_b = arr[7]; op_c = arr[2]; end
      3'd3: begin op_a = arr[2]; op_b = arr[4]; op_c = arr[6]; neg = 1'b1; end
      3'd4: begin op_a = arr[1]; op_b = arr[3]; op_c = arr[8]; neg = 1'b1; end
      3'd5: begin op_a = arr[5]; op_b = arr[7]; op_c = arr[0]; neg = 1'b1; end
      default: ;
    endcase
  end

  // Low WIDTH bits of a product depend only on the low bits of its operands.
  assign prod = op_a * op_b * op_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx  <= '0;
      term <= '0;
      acc  <= '0;
      for (int i = 0; i < 9; i++) arr[i] <= '0;
    end else if (clear) begin
      idx  <= '0;
      term <= '0;
      acc  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            arr[idx] <= in_data;
            if (idx == 4'd8) begin
              idx  <= '0;
              term <= '0;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        CALC: begin
          acc  <= neg ? acc - prod : acc + prod;
          term <= (term == 3'd5) ? 3'd0 : term + 3'd1;
        end
        DONE: begin
          if (out_ready) begin
            acc <= '0;
            idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC) || (state == DONE);
  assign result    = (state == DONE) ? acc : '0;
  assign state_dbg = state;

`ifdef DET3_SEQ_TERM_OUT_EN
  assign term_valid = (state == CALC);
  assign term_idx   = (state == CALC) ? term : 3'd0;
  assign term_data  = (state == CALC) ? prod : '0;
`endif

endmodule

// File: tb/tb_det3_seq.sv
// Self-checking bench for det3_seq: directed table, multi-cycle corner cases
// and random matrices against a cofactor-expansion reference model.
module tb_det3_seq;

  localparam int W = 16;
  typedef logic [8:0][W-1:0] mat_t;
  typedef struct packed {
    mat_t         m;
    logic [W-1:0] exp;
  } vec_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         busy;
  logic [1:0]   state_dbg;
`ifdef DET3_SEQ_TERM_OUT_EN
  logic         term_valid;
  logic [2:0]   term_idx;
  logic [W-1:0] term_data;
`endif

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] term_q[$];

  det3_seq #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .busy(busy), .state_dbg(state_dbg)
`ifdef DET3_SEQ_TERM_OUT_EN
    , .term_valid(term_valid), .term_idx(term_idx), .term_data(term_data)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic mat_t mk(input int a1, a2, a3, a4, a5, a6, a7, a8, a9);
    mat_t m;
    m[0] = W'(a1); m[1] = W'(a2); m[2] = W'(a3);
    m[3] = W'(a4); m[4] = W'(a5); m[5] = W'(a6);
    m[6] = W'(a7); m[7] = W'(a8); m[8] = W'(a9);
    return m;
  endfunction

  // Reference: cofactor expansion along the first row, reduced mod 2^W.
  function automatic logic [W-1:0] det_ref(input mat_t m);
    longint a [9];
    longint d;
    for (int i = 0; i < 9; i++) a[i] = longint'(m[i]);
    d = a[0] * (a[4] * a[8] - a[5] * a[7])
      - a[1] * (a[3] * a[8] - a[5] * a[6])
      + a[2] * (a[3] * a[7] - a[4] * a[6]);
    return d[W-1:0];
  endfunction

  function automatic logic [W-1:0] tri_prod(input mat_t m, input int i, j, k);
    longint p;
    p = longint'(m[i]) * longint'(m[j]) * longint'(m[k]);
    return p[W-1:0];
  endfunction

  // driver tasks
  task automatic load_elems(input mat_t m, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = m[i];
    end
  endtask

  // Waits for out_valid after a full load; checks latency, CALC-phase outputs,
  // the trace stream, the result and the return handshake.
  task automatic finish_txn(input mat_t m, input int stall, input string tag);
    int lat = 0;
    int nterm = 0;
    logic calc_ok = 1'b1;
    logic [W-1:0] exp_r;
    term_q = {};
    term_q.push_back(tri_prod(m, 0, 4, 8));
    term_q.push_back(tri_prod(m, 1, 5, 6));
    term_q.push_back(tri_prod(m, 3, 7, 2));
    term_q.push_back(tri_prod(m, 2, 4, 6));
    term_q.push_back(tri_prod(m, 1, 3, 8));
    term_q.push_back(tri_prod(m, 5, 7, 0));
    do begin
      @(negedge clock);
      in_valid = 1'b0;
      lat++;
      if (!out_valid) begin
        if (in_ready !== 1'b0 || busy !== 1'b1 || result !== '0) calc_ok = 1'b0;
`ifdef DET3_SEQ_TERM_OUT_EN
        check({tag, "_term_valid"}, {31'd0, term_valid}, 32'd1);
        check({tag, "_term_idx"}, {29'd0, term_idx}, nterm);
        if (term_q.size() > 0) check({tag, "_term_data"}, {16'd0, term_data}, {16'd0, term_q.pop_front()});
`endif
        nterm++;
      end
    end while (!out_valid && lat < 40);
    check({tag, "_latency_edges"}, lat - 1, 6);
    check({tag, "_calc_outputs"}, {31'd0, calc_ok}, 32'd1);
    exp_r = exp_q.pop_front();
    for (int s = 0; s < stall; s++) begin
      in_valid = s[0];
      in_data  = W'($urandom);
      check({tag, "_stall_result"}, {16'd0, result}, {16'd0, exp_r});
      check({tag, "_stall_ready"}, {30'd0, in_ready, out_valid}, 32'd1);
      @(negedge clock);
    end
    in_valid = 1'b0;
    check({tag, "_result"}, {16'd0, result}, {16'd0, exp_r});
`ifdef DET3_SEQ_TERM_OUT_EN
    check({tag, "_term_idle"}, {12'd0, term_valid, term_idx, term_data}, 32'd0);
`endif
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check({tag, "_after_hs"}, {29'd0, in_ready, out_valid, busy}, 32'd4);
  endtask

  task automatic run_txn(input mat_t m, input int stall, input string tag);
    exp_q.push_back(det_ref(m));
    load_elems(m, 9);
    finish_txn(m, stall, tag);
  endtask

  vec_t tbl [5];

  initial begin
    tbl[0] = '{m: mk(1, 0, 0, 0, 1, 0, 0, 0, 1), exp: 16'h0001};
    tbl[1] = '{m: mk(1, 2, 3, 0, 1, 4, 5, 6, 0), exp: 16'h0001};
    tbl[2] = '{m: mk(1, 2, 3, 4, 5, 6, 7, 8, 9), exp: 16'h0000};
    tbl[3] = '{m: mk(0, 1, 0, 1, 0, 0, 0, 0, 1), exp: 16'hFFFF};
    tbl[4] = '{m: mk(2, 0, 0, 0, 3, 0, 0, 0, 4), exp: 16'h0018};

    repeat (2) @(negedge clock);
    check("reset_outputs", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'h8);
    check("reset_result", {16'd0, result}, 32'd0);
    check("reset_state", {30'd0, state_dbg}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // directed table: expected values fixed by hand
    for (int t = 0; t < 5; t++) begin
      exp_q.push_back(tbl[t].exp);
      load_elems(tbl[t].m, 9);
      finish_txn(tbl[t].m, 0, $sformatf("tbl%0d", t));
    end

    // result held through a long stall with stray in_valid pulses
    exp_q.push_back(16'h0018);
    load_elems(tbl[4].m, 9);
    finish_txn(tbl[4].m, 5, "stall");

    // clear after four elements throws the partial matrix away
    load_elems(mk(9, 9, 9, 9, 0, 0, 0, 0, 0), 4);
    @(negedge clock);
    in_valid = 1'b1;
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    in_valid = 1'b0;
    check("clear_ready", {30'd0, in_ready, out_valid}, 32'd2);
    run_txn(tbl[0].m, 0, "after_clear");

    // reset in the third CALC cycle: nothing emitted, back in LOAD
    load_elems(tbl[4].m, 9);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("calc3_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_now", {29'd0, in_ready, out_valid, busy}, 32'd4);
    @(negedge clock);
    reset = 1'b0;
    begin
      logic saw_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clock);
        if (out_valid || !in_ready) saw_valid = 1'b1;
      end
      check("post_reset_idle", {31'd0, saw_valid}, 32'd0);
    end
    run_txn(tbl[0].m, 0, "after_reset");

    // random matrices, small and full-range elements
    for (int r = 0; r < 30; r++) begin
      mat_t m;
      for (int i = 0; i < 9; i++)
        m[i] = (r % 2 == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
      run_txn(m, $urandom_range(0, 3), $sformatf("rnd%0d", r));
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
